// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the RISC-V M-extension execute resource.
// A single iterative engine runs a shift-add multiply or a restoring divide at
// one bit per cycle on operand magnitudes. A one-cycle fixup stage then applies
// the sign rules, and the result is held until writeback takes it.
module muldiv_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [3:0]      mul_div_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] OP_MUL    = 4'b0011;
  localparam logic [3:0] OP_MULH   = 4'b0101;
  localparam logic [3:0] OP_MULHSU = 4'b0110;
  localparam logic [3:0] OP_MULHU  = 4'b0111;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1011;
  localparam logic [3:0] OP_REM    = 4'b1101;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched operation context and engine registers.
  logic [3:0]      op_q;
  logic [4:0]      rd_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic            special_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic [CNT_W-1:0] cnt_q;

  // Issue-side decode.
  logic            in_legal;
  logic            in_div;
  logic            in_sa;
  logic            in_sb;
  logic            in_dz;
  logic            in_ovf;
  logic            in_fast;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [XLEN-1:0] in_a_mag;
  logic [XLEN-1:0] in_b_mag;
  logic            accept;

  // Engine step and fixup values.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;
  logic [XLEN-1:0] hi_step;
  logic [XLEN-1:0] lo_step;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fix_res;

  assign op_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);

  // Decode the incoming op: legality, signedness, special cases, magnitudes.
  always_comb begin
    in_legal = 1'b0;
    in_sa    = 1'b0;
    in_sb    = 1'b0;
    in_div   = mul_div_op[3];
    unique case (mul_div_op)
      OP_MUL, OP_MULH: begin
        in_legal = 1'b1;
        in_sa    = 1'b1;
        in_sb    = 1'b1;
      end
      OP_MULHSU: begin
        in_legal = 1'b1;
        in_sa    = 1'b1;
      end
      OP_DIV, OP_REM: begin
        in_legal = 1'b1;
        in_sa    = 1'b1;
        in_sb    = 1'b1;
      end
      OP_MULHU, OP_DIVU, OP_REMU: begin
        in_legal = 1'b1;
      end
      default: begin
        in_legal = 1'b0;
      end
    endcase
    in_dz    = in_div & (rs2_val == '0);
    in_ovf   = in_div & in_sa & (rs1_val == MIN_NEG) & (rs2_val == '1);
    in_fast  = in_dz | in_ovf;
    in_a_neg = in_sa & rs1_val[XLEN-1];
    in_b_neg = in_sb & rs2_val[XLEN-1];
    in_a_mag = in_a_neg ? (~rs1_val + XLEN'(1)) : rs1_val;
    in_b_mag = in_b_neg ? (~rs2_val + XLEN'(1)) : rs2_val;
    accept   = op_valid & op_ready & in_legal & ~flush;
  end

  // One engine iteration: shift-add multiply or restoring divide step.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[XLEN-1:0] - opnd_q;
    if (op_q[3]) begin
      hi_step = div_ge ? div_diff : div_sh[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fixup and result selection from the finished engine state.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (a_neg_q ^ b_neg_q) ? (~prod + PW'(1)) : prod;
    mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
    if (special_q) begin
      q_fix = lo_q;
      r_fix = hi_q;
    end else begin
      q_fix = (a_neg_q ^ b_neg_q) ? (~lo_q + XLEN'(1)) : lo_q;
      r_fix = a_neg_q ? (~hi_q + XLEN'(1)) : hi_q;
    end
    if (op_q[3]) begin
      fix_res = op_q[2] ? r_fix : q_fix;
    end else begin
      fix_res = mul_res;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush wins over accept and over the writeback handshake.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = in_fast ? FIXUP : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        if (flush || result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on accept and engine iteration while calculating.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      special_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      op_q      <= mul_div_op;
      rd_q      <= rd_in;
      a_neg_q   <= in_a_neg;
      b_neg_q   <= in_b_neg;
      special_q <= in_fast;
      cnt_q     <= '0;
      if (in_fast) begin
        // Divide-by-zero: q = all ones, r = dividend; overflow: q = MIN, r = 0.
        hi_q   <= in_dz ? rs1_val : '0;
        lo_q   <= in_dz ? '1 : MIN_NEG;
        opnd_q <= '0;
      end else if (in_div) begin
        hi_q   <= '0;
        lo_q   <= in_a_mag;
        opnd_q <= in_b_mag;
      end else begin
        hi_q   <= '0;
        lo_q   <= in_b_mag;
        opnd_q <= in_a_mag;
      end
    end else if (state == CALC) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers: loaded when fixup hands over to DONE, valid only in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid <= 1'b0;
      result       <= '0;
      rd_out       <= '0;
    end else begin
      result_valid <= (state_next == DONE);
      if ((state == FIXUP) && (state_next == DONE)) begin
        result <= fix_res;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors with literal results,
// plus a transaction-level model compared against the outputs every cycle.
module tb_muldiv_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            op_valid;
  logic            op_ready;
  logic [3:0]      mul_div_op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            flush;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .mul_div_op(mul_div_op), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_in(rd_in), .flush(flush), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .rd_out(rd_out), .busy(busy)
  );

  // ---------------- reference model ----------------
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0011, 4'b0101, 4'b0110, 4'b0111,
      4'b1001, 4'b1011, 4'b1101, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_fast(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn_div;
    sgn_div = (op == 4'b1001) || (op == 4'b1101);
    if (!op[3]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return sgn_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'b0011: begin p = 64'(sa * sb); return p[31:0]; end
      4'b0101: begin p = 64'(sa * sb); return p[63:32]; end
      4'b0110: begin p = 64'(sa * ub); return p[63:32]; end
      4'b0111: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      4'b1001: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      4'b1011: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1101: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      4'b1111: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  logic        m_pend = 1'b0;
  int          m_age  = 0;
  int          m_lat  = 0;
  logic [31:0] m_res  = '0;
  logic [4:0]  m_rd   = '0;
  logic        chk_en = 1'b0;
  logic        m_valid;

  assign m_valid = m_pend && (m_age >= m_lat);

  // Transaction model: one op in flight, fixed latency, flush/reset kill it.
  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
    end else if (m_pend) begin
      if (flush) m_pend <= 1'b0;
      else if (m_valid && result_ready) m_pend <= 1'b0;
      else m_age <= m_age + 1;
    end else if (op_valid && is_legal(mul_div_op) && !flush) begin
      m_pend <= 1'b1;
      m_age  <= 1;
      m_lat  <= is_fast(mul_div_op, rs1_val, rs2_val) ? 2 : 34;
      m_res  <= ref_res(mul_div_op, rs1_val, rs2_val);
      m_rd   <= rd_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_result_valid", 32'(result_valid), 32'(m_valid));
      chk("m_busy", 32'(busy), 32'(m_pend));
      chk("m_op_ready", 32'(op_ready), 32'(!m_pend && !rst));
      if (m_valid) begin
        chk("m_result", result, m_res);
        chk("m_rd_out", 32'(rd_out), 32'(m_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!result_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n;
    op_valid = 1'b1; mul_div_op = op; rs1_val = a; rs2_val = b; rd_in = rd;
    step();
    op_valid = 1'b0;
    wait_valid(n);
    chk("latency", 32'(n), 32'(lat));
    chk("result", result, exp);
    chk("rd_out", 32'(rd_out), 32'(rd));
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] ill [8];
    ill = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010, 4'b1100, 4'b1110};

    rst = 1'b1; op_valid = 1'b0; mul_div_op = '0; rs1_val = '0; rs2_val = '0;
    rd_in = '0; flush = 1'b0; result_ready = 1'b0;
    repeat (3) step();
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    step();
    chk("idle_op_ready", 32'(op_ready), 32'd1);

    // Multiply group
    run_op(4'b0011, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34);
    run_op(4'b0111, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34);
    run_op(4'b0101, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 34);
    run_op(4'b0110, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34);
    run_op(4'b0011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'h0000_0001, 34);
    run_op(4'b0101, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 34);
    // Divide group
    run_op(4'b1001, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 34);
    run_op(4'b1101, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 34);
    run_op(4'b1011, 32'd100,        32'd7,         5'd9,  32'd14,        34);
    run_op(4'b1111, 32'd100,        32'd7,         5'd10, 32'd2,         34);
    run_op(4'b1101, 32'd7,          32'hFFFF_FFFE, 5'd11, 32'd1,         34);
    run_op(4'b1001, 32'h8000_0000,  32'd2,         5'd12, 32'hC000_0000, 34);
    run_op(4'b1011, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         34);
    // Fast path: divide by zero and signed overflow
    run_op(4'b1001, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 2);
    run_op(4'b1101, 32'd5,          32'd0,         5'd15, 32'd5,         2);
    run_op(4'b1001, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2);
    run_op(4'b1101, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         2);

    // Backpressure in DONE, then back-to-back accept after the handshake
    op_valid = 1'b1; mul_div_op = 4'b0111; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; rd_in = 5'd9;
    step();
    op_valid = 1'b0;
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'd34);
    op_valid = 1'b1; mul_div_op = 4'b1011; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_result", result, 32'hFFFF_FFFE);
      chk("bp_rd_out", 32'(rd_out), 32'd9);
      chk("bp_op_ready", 32'(op_ready), 32'd0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("bp_ready_after_hs", 32'(op_ready), 32'd1);
    step();
    op_valid = 1'b0;
    chk("bp_accepted", 32'(busy), 32'd1);
    wait_valid(n);
    chk("bp2_latency", 32'(n), 32'd34);
    chk("bp2_result", result, 32'd14);
    chk("bp2_rd_out", 32'(rd_out), 32'd3);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Flush on CALC cycle 10
    op_valid = 1'b1; mul_div_op = 4'b1011; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd20;
    step();
    op_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_valid", 32'(result_valid), 32'd0);
    chk("fl_op_ready", 32'(op_ready), 32'd1);
    repeat (40) step();

    // Flush in DONE wins over result_ready
    op_valid = 1'b1; mul_div_op = 4'b1001; rs1_val = 32'd9; rs2_val = 32'd0; rd_in = 5'd21;
    step();
    op_valid = 1'b0;
    wait_valid(n);
    chk("fd_latency", 32'(n), 32'd2);
    flush = 1'b1; result_ready = 1'b1;
    step();
    flush = 1'b0; result_ready = 1'b0;
    chk("fd_valid", 32'(result_valid), 32'd0);
    chk("fd_busy", 32'(busy), 32'd0);

    // Reset on CALC cycle 20 (result still holds a nonzero earlier value)
    op_valid = 1'b1; mul_div_op = 4'b0011; rs1_val = 32'd123; rs2_val = 32'd456; rd_in = 5'd22;
    step();
    op_valid = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    chk("mr_valid", 32'(result_valid), 32'd0);
    chk("mr_result", result, 32'd0);
    chk("mr_rd_out", 32'(rd_out), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_op_ready", 32'(op_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("mr_op_ready_after", 32'(op_ready), 32'd1);

    // Illegal encodings are ignored
    for (int i = 0; i < 8; i++) begin
      op_valid = 1'b1; mul_div_op = ill[i]; rs1_val = 32'd10; rs2_val = 32'd2; rd_in = 5'd1;
      step();
      chk("ill_busy", 32'(busy), 32'd0);
      chk("ill_op_ready", 32'(op_ready), 32'd1);
    end
    op_valid = 1'b0;
    repeat (4) step();

    // Operation still works after all of the above
    run_op(4'b0011, 32'd12, 32'd11, 5'd31, 32'd132, 34);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the M-extension execute resource. It accepts one decoded mul_div_op with its operands, runs a single shared iterative engine (shift-add multiply or restoring divide, 1 bit per cycle), applies RISC-V sign and special-case fixups, and holds the result until writeback takes it. It asserts busy so the pipeline stalls while an operation is in flight, and it supports flush on exception or redirect.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN
CNT_W, 6, iteration counter width (clog2(XLEN)+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
op_valid  in  1  request valid from decode/issue
op_ready  out  1  block idle, can accept
mul_div_op  in  4  decoder encoding: 0011 MUL, 0101 MULH, 0110 MULHSU, 0111 MULHU, 1001 DIV, 1011 DIVU, 1101 REM, 1111 REMU
rs1_val  in  XLEN  operand a / dividend
rs2_val  in  XLEN  operand b / divisor
rd_in  in  5  destination tag
flush  in  1  kill in-flight op (exception_pending / redirect)
result_valid  out  1  result available
result_ready  in  1  writeback consumes result
result  out  XLEN  final value
rd_out  out  5  tag of result
busy  out  1  stall request to pipeline

Behaviour:
- States: IDLE, CALC, FIXUP, DONE. op_ready = (state==IDLE) & ~rst. busy = (state!=IDLE).
- Reset (sync): state IDLE; result_valid 0, result 0, rd_out 0, busy 0, counter 0. Reset mid-operation aborts it with no result.
- Accept when op_valid & op_ready & legal op & ~flush. Operands, op and rd are latched.
- Illegal codes (0000, 0001, 0010, 0100, 1000, 1010, 1100, 1110) are ignored: no state change, op_ready stays 1.
- IDLE->CALC on accept. If the op is a divide and rs2==0, or a signed DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF, go IDLE->FIXUP instead (fast path).
- CALC: runs exactly XLEN cycles on operand magnitudes.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - Counter counts 0..XLEN-1, then CALC->FIXUP.
- Signedness: MUL/MULH treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU, DIVU and REMU are unsigned. DIV and REM are signed.
- FIXUP (1 cycle), then ->DONE:
  - Multiply: negate the product if the operand signs differ. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Divide: negate the quotient if the signs differ. The remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Overflow: quotient = 0x80000000, remainder = 0.
- DONE: result_valid=1. result and rd_out are stable until result_ready. On the handshake, go DONE->IDLE. The next op can be accepted 1 cycle after the handshake.
- Latency from the accept cycle to result_valid high: XLEN+2 (34) normally, 2 on the fast path.
- flush in CALC/FIXUP/DONE: go to IDLE next cycle, clear result_valid, produce no result. flush has priority over result_ready and over accept in the same cycle.
- op_valid while not ready is ignored and not queued. The issuing side holds it under busy.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> result 0xFFFFFFEB, rd_out 5. result_valid rises exactly 34 cycles after accept; busy high throughout.
- rs1=rs2=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both valid 2 cycles after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Backpressure: hold result_ready low for 10 cycles in DONE. result, rd_out and result_valid stay stable; op_ready stays 0; a new op_valid is not accepted. Raise result_ready: the next op is accepted the cycle after the handshake.
- flush on CALC cycle 10 -> IDLE next cycle, no result_valid, op_ready 1. rst asserted on CALC cycle 20 -> all outputs at reset values the next cycle. Illegal op 0100 with op_valid -> no state change.
